mem_ctrl: RTL and testbench

Memory bus controller between the CPU core's memory-request outputs (`mem_rd`, `mem_wr`, MAR address, MDR write data) and an external variable-latency word memory. It latches one request, drives a req/ack handshake to memory, returns read data for the MDR, and reports completion. It also reports errors for illegal requests and for accesses the memory never acknowledges within a bounded time.

---
 rtl/mem_ctrl.sv | 141 ++++++++++++++
 tb/tb_mem_ctrl.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_ctrl.sv
// mem_ctrl: memory bus controller between the core's request strobes and an
// external variable-latency word memory.
//
// One request is latched in IDLE and presented to memory over a req/ack
// handshake. The access finishes in one of three ways:
//   - the memory acknowledges it (done),
//   - no ack arrives within TIMEOUT cycles (err),
//   - the request is illegal, with read and write both set (err).
//
// Ports:
//   clk, rst             system clock, synchronous active-high reset
//   mem_rd, mem_wr       request strobes from control (level-sampled in IDLE)
//   addr, wr_data        word address (MAR) and write data (MDR)
//   rd_data              registered read data, updated only by a completed read
//   busy                 access outstanding
//   done, err            one-cycle completion / abort pulses
//   ext_req, ext_we      memory request and direction (1 = write)
//   ext_addr, ext_wdata  latched address and write data
//   ext_ack, ext_rdata   memory acknowledge and read data (same cycle)
module mem_ctrl #(
  parameter int unsigned TIMEOUT = 255  // legal range 1..65535
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_rd,
  input  logic        mem_wr,
  input  logic [31:0] addr,
  input  logic [31:0] wr_data,
  output logic [31:0] rd_data,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic        ext_req,
  output logic        ext_we,
  output logic [31:0] ext_addr,
  output logic [31:0] ext_wdata,
  input  logic        ext_ack,
  input  logic [31:0] ext_rdata
);

  localparam logic [15:0] TimeoutCnt = 16'(TIMEOUT);

  typedef enum logic [1:0] {StIdle, StReq, StDone, StErr} state_e;

  state_e      state_q, state_d;
  logic [15:0] cnt_q;
  logic [15:0] cnt_inc;
  logic [31:0] rd_data_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic        we_q;
  logic        accept;

  assign cnt_inc = cnt_q + 16'd1;
  assign accept  = (state_q == StIdle) && (mem_rd ^ mem_wr);

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (mem_rd && mem_wr) begin
          state_d = StErr;
        end else if (mem_rd ^ mem_wr) begin
          state_d = StReq;
        end
      end
      StReq: begin
        // Ack takes priority over a timeout reached at the same edge.
        if (ext_ack) begin
          state_d = StDone;
        end else if (cnt_inc == TimeoutCnt) begin
          state_d = StErr;
        end
      end
      StDone:  state_d = StIdle;
      StErr:   state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Outputs decoded from state only
  always_comb begin
    busy    = 1'b0;
    ext_req = 1'b0;
    done    = 1'b0;
    err     = 1'b0;
    unique case (state_q)
      StReq: begin
        busy    = 1'b1;
        ext_req = 1'b1;
      end
      StDone:  done = 1'b1;
      StErr:   err  = 1'b1;
      default: ;
    endcase
  end

  // Request latch, wait counter and read data register
  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q    <= '0;
      wdata_q   <= '0;
      we_q      <= 1'b0;
      cnt_q     <= '0;
      rd_data_q <= '0;
    end else begin
      if (accept) begin
        addr_q  <= addr;
        wdata_q <= wr_data;
        we_q    <= mem_wr;
        cnt_q   <= '0;
      end
      if (state_q == StReq) begin
        if (ext_ack) begin
          if (!we_q) begin
            rd_data_q <= ext_rdata;
          end
        end else begin
          // Leaving REQ at TIMEOUT keeps this from ever wrapping.
          cnt_q <= cnt_inc;
        end
      end
    end
  end

  assign rd_data   = rd_data_q;
  assign ext_we    = we_q;
  assign ext_addr  = addr_q;
  assign ext_wdata = wdata_q;

endmodule

// File: tb/tb_mem_ctrl.sv
// Bench for mem_ctrl: two instances (default TIMEOUT and TIMEOUT=4) share one
// stimulus stream and are compared each cycle against a transaction-level model,
// with directed literal checks on top.
module tb_mem_ctrl;

  localparam int unsigned TimeoutA = 255;
  localparam int unsigned TimeoutB = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        mem_rd = 1'b0;
  logic        mem_wr = 1'b0;
  logic        ext_ack = 1'b0;
  logic [31:0] addr = '0;
  logic [31:0] wr_data = '0;
  logic [31:0] ext_rdata = '0;

  logic [31:0] rd_data   [2];
  logic [31:0] ext_addr  [2];
  logic [31:0] ext_wdata [2];
  logic        busy      [2];
  logic        done      [2];
  logic        err       [2];
  logic        ext_req   [2];
  logic        ext_we    [2];

  int n_chk  = 0;
  int n_fail = 0;
  bit chk_on = 1'b0;

  always #5 clk = ~clk;

  mem_ctrl #(.TIMEOUT(TimeoutA)) dut_a (
    .clk(clk), .rst(rst), .mem_rd(mem_rd), .mem_wr(mem_wr), .addr(addr),
    .wr_data(wr_data), .rd_data(rd_data[0]), .busy(busy[0]), .done(done[0]),
    .err(err[0]), .ext_req(ext_req[0]), .ext_we(ext_we[0]), .ext_addr(ext_addr[0]),
    .ext_wdata(ext_wdata[0]), .ext_ack(ext_ack), .ext_rdata(ext_rdata)
  );

  mem_ctrl #(.TIMEOUT(TimeoutB)) dut_b (
    .clk(clk), .rst(rst), .mem_rd(mem_rd), .mem_wr(mem_wr), .addr(addr),
    .wr_data(wr_data), .rd_data(rd_data[1]), .busy(busy[1]), .done(done[1]),
    .err(err[1]), .ext_req(ext_req[1]), .ext_we(ext_we[1]), .ext_addr(ext_addr[1]),
    .ext_wdata(ext_wdata[1]), .ext_ack(ext_ack), .ext_rdata(ext_rdata)
  );

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, got, exp, $time);
    end
  endtask

  // Transaction-level model: an access is either outstanding (counting waited
  // cycles) or has just produced a done/err pulse, which costs one dead cycle.
  int          tmo     [2];
  bit          m_out   [2];
  bit          m_done  [2];
  bit          m_err   [2];
  bit          m_we    [2];
  int          m_wait  [2];
  logic [31:0] m_rd    [2];
  logic [31:0] m_addr  [2];
  logic [31:0] m_wdata [2];

  initial begin
    tmo[0] = int'(TimeoutA);
    tmo[1] = int'(TimeoutB);
  end

  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (rst) begin
        m_out[i] = 0; m_done[i] = 0; m_err[i] = 0; m_we[i] = 0; m_wait[i] = 0;
        m_rd[i] = '0; m_addr[i] = '0; m_wdata[i] = '0;
      end else if (m_done[i] || m_err[i]) begin
        m_done[i] = 0;
        m_err[i]  = 0;
      end else if (m_out[i]) begin
        m_wait[i] = m_wait[i] + 1;
        if (ext_ack) begin
          m_out[i]  = 0;
          m_done[i] = 1;
          if (!m_we[i]) m_rd[i] = ext_rdata;
        end else if (m_wait[i] == tmo[i]) begin
          m_out[i] = 0;
          m_err[i] = 1;
        end
      end else if (mem_rd && mem_wr) begin
        m_err[i] = 1;
      end else if (mem_rd || mem_wr) begin
        m_out[i]   = 1;
        m_wait[i]  = 0;
        m_we[i]    = mem_wr;
        m_addr[i]  = addr;
        m_wdata[i] = wr_data;
      end
    end
  end

  // Per-cycle comparison against the model, on the inactive edge.
  always @(negedge clk) begin
    if (chk_on) begin
      for (int i = 0; i < 2; i++) begin
        check($sformatf("busy[%0d]", i), 32'(busy[i]), 32'(m_out[i]));
        check($sformatf("ext_req[%0d]", i), 32'(ext_req[i]), 32'(m_out[i]));
        check($sformatf("done[%0d]", i), 32'(done[i]), 32'(m_done[i]));
        check($sformatf("err[%0d]", i), 32'(err[i]), 32'(m_err[i]));
        check($sformatf("ext_we[%0d]", i), 32'(ext_we[i]), 32'(m_we[i]));
        check($sformatf("ext_addr[%0d]", i), ext_addr[i], m_addr[i]);
        check($sformatf("ext_wdata[%0d]", i), ext_wdata[i], m_wdata[i]);
        check($sformatf("rd_data[%0d]", i), rd_data[i], m_rd[i]);
      end
    end
  end

  task automatic wait_idle();
    bit ok = 1'b0;
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      if (!busy[0] && !busy[1] && !done[0] && !done[1] && !err[0] && !err[1]) begin
        ok = 1'b1;
        break;
      end
    end
    check("wait_idle_bound", 32'(ok), 32'd1);
    @(negedge clk);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset
    @(posedge clk);
    #1 chk_on = 1'b1;
    repeat (2) @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      check("rst_busy", 32'(busy[i]), 32'd0);
      check("rst_rd_data", rd_data[i], 32'h0);
      check("rst_ext_addr", ext_addr[i], 32'h0);
    end
    rst = 1'b0;
    @(negedge clk);

    // Read, ack sampled at edge 1
    mem_rd = 1'b1; addr = 32'h100;
    @(negedge clk);                      // cycle 0
    mem_rd = 1'b0;
    check("rd_ext_req", 32'(ext_req[0]), 32'd1);
    check("rd_ext_addr", ext_addr[0], 32'h100);
    check("rd_ext_we", 32'(ext_we[0]), 32'd0);
    ext_ack = 1'b1; ext_rdata = 32'hCAFEBABE;
    @(negedge clk);                      // cycle 1
    ext_ack = 1'b0; ext_rdata = '0;
    for (int i = 0; i < 2; i++) begin
      check("rd_done", 32'(done[i]), 32'd1);
      check("rd_data", rd_data[i], 32'hCAFEBABE);
    end
    @(negedge clk);                      // cycle 2
    check("rd_done_cleared", 32'(done[0]), 32'd0);
    wait_idle();

    // Write, ack sampled at edge 5 (times out on the TIMEOUT=4 instance)
    mem_wr = 1'b1; addr = 32'h20; wr_data = 32'h12345678;
    @(negedge clk);
    mem_wr = 1'b0; addr = '0; wr_data = '0;
    for (int c = 0; c < 5; c++) begin
      check("wr_ext_req", 32'(ext_req[0]), 32'd1);
      check("wr_ext_we", 32'(ext_we[0]), 32'd1);
      check("wr_ext_wdata", ext_wdata[0], 32'h12345678);
      if (c == 4) begin
        check("wr_tmo4_err", 32'(err[1]), 32'd1);
        ext_ack = 1'b1;
      end
      @(negedge clk);
    end
    ext_ack = 1'b0;
    check("wr_done", 32'(done[0]), 32'd1);
    check("wr_no_err", 32'(err[0]), 32'd0);
    check("wr_rd_data_kept", rd_data[0], 32'hCAFEBABE);
    check("wr_ack_idle_ignored", 32'(done[1]), 32'd0);
    wait_idle();

    // Timeout with no ack
    mem_rd = 1'b1; addr = 32'h44;
    @(negedge clk);
    mem_rd = 1'b0;
    for (int c = 0; c < 4; c++) begin
      check("tmo_ext_req", 32'(ext_req[1]), 32'd1);
      @(negedge clk);
    end
    check("tmo_err", 32'(err[1]), 32'd1);
    check("tmo_req_low", 32'(ext_req[1]), 32'd0);
    check("tmo_rd_data_kept", rd_data[1], 32'hCAFEBABE);
    wait_idle();

    // Ack at exactly edge TIMEOUT on the small instance
    mem_rd = 1'b1; addr = 32'h48;
    @(negedge clk);
    mem_rd = 1'b0;
    repeat (3) @(negedge clk);           // cycle 3
    ext_ack = 1'b1; ext_rdata = 32'h0BADF00D;
    @(negedge clk);                      // cycle 4
    ext_ack = 1'b0; ext_rdata = '0;
    check("edge_ack_done", 32'(done[1]), 32'd1);
    check("edge_ack_no_err", 32'(err[1]), 32'd0);
    check("edge_ack_rd_data", rd_data[1], 32'h0BADF00D);
    wait_idle();

    // Illegal request
    mem_rd = 1'b1; mem_wr = 1'b1; addr = 32'h77;
    @(negedge clk);
    mem_rd = 1'b0; mem_wr = 1'b0;
    check("ill_err", 32'(err[0]), 32'd1);
    check("ill_no_req", 32'(ext_req[0]), 32'd0);
    @(negedge clk);
    check("ill_err_cleared", 32'(err[1]), 32'd0);
    check("ill_no_req_after", 32'(ext_req[1]), 32'd0);
    wait_idle();

    // Reset at edge 2 of a pending read
    mem_rd = 1'b1; addr = 32'h300;
    @(negedge clk);                      // cycle 0
    mem_rd = 1'b0;
    @(negedge clk);                      // cycle 1
    rst = 1'b1;
    @(negedge clk);                      // cycle 2
    rst = 1'b0;
    for (int i = 0; i < 2; i++) begin
      check("rstp_ext_req", 32'(ext_req[i]), 32'd0);
      check("rstp_busy", 32'(busy[i]), 32'd0);
      check("rstp_rd_data", rd_data[i], 32'h0);
      check("rstp_ext_addr", ext_addr[i], 32'h0);
    end
    @(negedge clk);
    check("rstp_no_done", 32'(done[0]), 32'd0);
    check("rstp_no_err", 32'(err[0]), 32'd0);
    wait_idle();

    // mem_rd and ext_ack held high: one access every 3 cycles
    mem_rd = 1'b1; addr = 32'h500; ext_ack = 1'b1; ext_rdata = 32'h11110000;
    @(negedge clk);                      // cycle 0
    for (int c = 0; c < 9; c++) begin
      for (int i = 0; i < 2; i++) begin
        check($sformatf("b2b_done_c%0d", c), 32'(done[i]), 32'((c % 3) == 1));
      end
      if (c == 8) begin
        mem_rd = 1'b0;
        ext_ack = 1'b0;
      end
      @(negedge clk);
    end
    check("b2b_rd_data", rd_data[0], 32'h11110000);
    wait_idle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
